// File: rtl/demux_lane_buffer.sv
// Lane buffer behind the 1-to-8 byte demux: per-lane FIFOs with
// independent consumer handshakes and a demux integrity check.
module demux_lane_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       in_sel,
  input  logic [63:0]      in_lanes,
  output logic             in_ready,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [63:0]      out_data,
  output logic [7:0]       lane_full,
  output logic [CNT_W-1:0] accept_cnt,
  output logic             err_nonsel
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [7:0]    mem    [8][DEPTH];
  logic [AW-1:0] wr_ptr [8];
  logic [AW-1:0] rd_ptr [8];
  logic [CW-1:0] count  [8];

  logic [7:0] push;
  logic [7:0] pop;
  logic       accept;
  logic       nonsel_hit;
  logic [7:0] sel_byte;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      lane_full[k] = (count[k] == FULL);
      out_valid[k] = (count[k] != '0);
      out_data[8*k +: 8] = (count[k] != '0) ?
                           mem[k][rd_ptr[k]] : 8'h00;
    end
  end

  // ready looks only at stored state, never at out_ready
  assign in_ready = !lane_full[in_sel];
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid & out_ready;
  assign push     = accept ? (8'b1 << in_sel) : 8'b0;
  assign sel_byte = in_lanes[8*in_sel +: 8];

  always_comb begin
    nonsel_hit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (3'(k) != in_sel && in_lanes[8*k +: 8] != 8'h00)
        nonsel_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
      accept_cnt <= '0;
      err_nonsel <= 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (push[k])
          wr_ptr[k] <= wr_ptr[k] + AW'(1);
        if (pop[k])
          rd_ptr[k] <= rd_ptr[k] + AW'(1);
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + CW'(1);
          2'b01:   count[k] <= count[k] - CW'(1);
          default: count[k] <= count[k];
        endcase
      end
      if (accept)
        accept_cnt <= accept_cnt + CNT_W'(1);
      if (accept && nonsel_hit)
        err_nonsel <= 1'b1;
    end
  end

  // storage needs no reset; reads are masked by count
  always_ff @(posedge clk) begin
    if (rst_n && accept)
      mem[in_sel][wr_ptr[in_sel]] <= sel_byte;
  end

endmodule
